// File: rtl/rs_age_ordered_pkg.sv
// Shared types for the age-ordered reservation station: entry layout, opcode
// type and the ROB-relative age helper used for flush ordering.
package rs_age_ordered_pkg;

    localparam int RS_DATA_W    = 64;
    localparam int RS_ROB_IDX_W = 4;
    localparam int RS_OP_W      = 5;

    typedef logic [RS_OP_W-1:0] fu_op_t;

    typedef struct packed {
        logic                    valid;
        logic [RS_DATA_W-1:0]    value;
        logic [RS_ROB_IDX_W-1:0] idx;
    } rs_opnd_t;

    typedef struct packed {
        logic                    valid;
        fu_op_t                  op;
        logic [RS_ROB_IDX_W-1:0] dst_idx;
        rs_opnd_t                a;
        rs_opnd_t                b;
        logic                    uses_nzcv;
        logic                    nzcv_valid;
        logic [3:0]              nzcv;
        logic [RS_ROB_IDX_W-1:0] nzcv_idx;
        logic                    set_nzcv;
        logic [3:0]              cond;
    } rs_entry_t;

    // Distance from the ROB head; wraps naturally in the tag width.
    function automatic logic [RS_ROB_IDX_W-1:0] rob_age(
        input logic [RS_ROB_IDX_W-1:0] tag,
        input logic [RS_ROB_IDX_W-1:0] head
    );
        return tag - head;
    endfunction

endpackage

// File: rtl/rs_age_ordered_age_select.sv
// Oldest-ready picker: age[i][j] set means entry i is older than entry j.
module rs_age_select #(
    parameter int RS_DEPTH = 8,
    localparam int IDX_W = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0]               ready,
    input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age,
    output logic [RS_DEPTH-1:0]               oldest_oh,
    output logic [IDX_W-1:0]                  oldest_idx,
    output logic                              any_ready
);

    for (genvar i = 0; i < RS_DEPTH; i++) begin : g_sel
        logic [RS_DEPTH-1:0] older_rdy;
        for (genvar j = 0; j < RS_DEPTH; j++) begin : g_col
            assign older_rdy[j] = ready[j] & age[j][i];
        end
        // Winner: ready with no ready entry older than it.
        assign oldest_oh[i] = ready[i] & ~|older_rdy;
    end

    always_comb begin
        oldest_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (oldest_oh[i]) oldest_idx = oldest_idx | IDX_W'(i);
        end
    end

    assign any_ready = |ready;

endmodule

// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station for one FU. Optional statistics outputs
// (occupancy, full-stall counter) are built when RS_STATS_EN is defined.
module rs_age_ordered
    import rs_age_ordered_pkg::*;
#(
    parameter int RS_DEPTH  = 8,
    parameter int DATA_W    = RS_DATA_W,
    parameter int ROB_IDX_W = RS_ROB_IDX_W,
    parameter int OP_W      = RS_OP_W
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_alloc_valid,
    output logic                 out_alloc_ready,
    input  logic [OP_W-1:0]      in_alloc_op,
    input  logic [ROB_IDX_W-1:0] in_alloc_dst_idx,
    input  logic                 in_alloc_a_valid,
    input  logic [DATA_W-1:0]    in_alloc_a_value,
    input  logic [ROB_IDX_W-1:0] in_alloc_a_idx,
    input  logic                 in_alloc_b_valid,
    input  logic [DATA_W-1:0]    in_alloc_b_value,
    input  logic [ROB_IDX_W-1:0] in_alloc_b_idx,
    input  logic                 in_alloc_uses_nzcv,
    input  logic                 in_alloc_nzcv_valid,
    input  logic [3:0]           in_alloc_nzcv,
    input  logic [ROB_IDX_W-1:0] in_alloc_nzcv_idx,
    input  logic                 in_alloc_set_nzcv,
    input  logic [3:0]           in_alloc_cond,
    input  logic                 in_bcast_valid,
    input  logic [ROB_IDX_W-1:0] in_bcast_idx,
    input  logic [DATA_W-1:0]    in_bcast_value,
    input  logic                 in_bcast_set_nzcv,
    input  logic [3:0]           in_bcast_nzcv,
    input  logic                 in_flush,
    input  logic [ROB_IDX_W-1:0] in_flush_idx,
    input  logic [ROB_IDX_W-1:0] in_rob_head_idx,
    output logic                 out_issue_valid,
    input  logic                 in_issue_ready,
    output logic [OP_W-1:0]      out_issue_op,
    output logic [DATA_W-1:0]    out_issue_a,
    output logic [DATA_W-1:0]    out_issue_b,
    output logic [ROB_IDX_W-1:0] out_issue_dst_idx,
    output logic [3:0]           out_issue_nzcv,
    output logic                 out_issue_set_nzcv,
    output logic [3:0]           out_issue_cond
`ifdef RS_STATS_EN
    ,
    output logic [$clog2(RS_DEPTH+1)-1:0] out_occupancy,
    output logic [31:0]                   out_full_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    rs_entry_t ent_q [RS_DEPTH];
    rs_entry_t ent_d [RS_DEPTH];
    rs_entry_t new_ent;

    logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;
    logic [RS_DEPTH-1:0] valid_vec, ready_vec, squash_vec, issue_oh;
    logic [IDX_W-1:0]    issue_idx, alloc_idx;
    logic [ROB_IDX_W-1:0] flush_age;
    logic any_ready, has_free, alloc_fire, issue_fire;

    assign flush_age = rob_age(in_flush_idx, in_rob_head_idx);

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_vec[i]  = ent_q[i].valid;
            ready_vec[i]  = ent_q[i].valid & ent_q[i].a.valid & ent_q[i].b.valid &
                            (~ent_q[i].uses_nzcv | ent_q[i].nzcv_valid);
            squash_vec[i] = in_flush &&
                            (rob_age(ent_q[i].dst_idx, in_rob_head_idx) > flush_age);
        end
    end

    // Lowest-index free slot: scan downward so the smallest index wins.
    always_comb begin
        has_free  = 1'b0;
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                has_free  = 1'b1;
                alloc_idx = IDX_W'(i);
            end
        end
    end

    assign out_alloc_ready = has_free;
    assign alloc_fire      = in_alloc_valid & has_free & ~in_flush;

    rs_age_select #(.RS_DEPTH(RS_DEPTH)) u_sel (
        .ready     (ready_vec),
        .age       (age_q),
        .oldest_oh (issue_oh),
        .oldest_idx(issue_idx),
        .any_ready (any_ready)
    );

    assign out_issue_valid = any_ready;
    assign issue_fire      = any_ready & in_issue_ready;

    always_comb begin
        out_issue_op       = '0;
        out_issue_a        = '0;
        out_issue_b        = '0;
        out_issue_dst_idx  = '0;
        out_issue_nzcv     = '0;
        out_issue_set_nzcv = 1'b0;
        out_issue_cond     = '0;
        if (any_ready) begin
            out_issue_op       = ent_q[issue_idx].op;
            out_issue_a        = ent_q[issue_idx].a.value;
            out_issue_b        = ent_q[issue_idx].b.value;
            out_issue_dst_idx  = ent_q[issue_idx].dst_idx;
            out_issue_nzcv     = ent_q[issue_idx].nzcv;
            out_issue_set_nzcv = ent_q[issue_idx].set_nzcv;
            out_issue_cond     = ent_q[issue_idx].cond;
        end
    end

    // Incoming entry, with same-cycle broadcast bypassed in so no wakeup is lost.
    always_comb begin
        new_ent            = '0;
        new_ent.valid      = 1'b1;
        new_ent.op         = in_alloc_op;
        new_ent.dst_idx    = in_alloc_dst_idx;
        new_ent.a.valid    = in_alloc_a_valid;
        new_ent.a.value    = in_alloc_a_value;
        new_ent.a.idx      = in_alloc_a_idx;
        new_ent.b.valid    = in_alloc_b_valid;
        new_ent.b.value    = in_alloc_b_value;
        new_ent.b.idx      = in_alloc_b_idx;
        new_ent.uses_nzcv  = in_alloc_uses_nzcv;
        new_ent.nzcv_valid = in_alloc_nzcv_valid;
        new_ent.nzcv       = in_alloc_nzcv;
        new_ent.nzcv_idx   = in_alloc_nzcv_idx;
        new_ent.set_nzcv   = in_alloc_set_nzcv;
        new_ent.cond       = in_alloc_cond;
        if (in_bcast_valid) begin
            if (!in_alloc_a_valid && in_alloc_a_idx == in_bcast_idx) begin
                new_ent.a.valid = 1'b1;
                new_ent.a.value = in_bcast_value;
            end
            if (!in_alloc_b_valid && in_alloc_b_idx == in_bcast_idx) begin
                new_ent.b.valid = 1'b1;
                new_ent.b.value = in_bcast_value;
            end
            if (in_bcast_set_nzcv && !in_alloc_nzcv_valid && in_alloc_nzcv_idx == in_bcast_idx) begin
                new_ent.nzcv_valid = 1'b1;
                new_ent.nzcv       = in_bcast_nzcv;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (in_bcast_valid) begin
                if (!ent_q[i].a.valid && ent_q[i].a.idx == in_bcast_idx) begin
                    ent_d[i].a.valid = 1'b1;
                    ent_d[i].a.value = in_bcast_value;
                end
                if (!ent_q[i].b.valid && ent_q[i].b.idx == in_bcast_idx) begin
                    ent_d[i].b.valid = 1'b1;
                    ent_d[i].b.value = in_bcast_value;
                end
                if (in_bcast_set_nzcv && !ent_q[i].nzcv_valid && ent_q[i].nzcv_idx == in_bcast_idx) begin
                    ent_d[i].nzcv_valid = 1'b1;
                    ent_d[i].nzcv       = in_bcast_nzcv;
                end
            end
            if (squash_vec[i] || (issue_fire && issue_oh[i])) ent_d[i].valid = 1'b0;
            if (alloc_fire && alloc_idx == IDX_W'(i)) ent_d[i] = new_ent;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
            age_q <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
            // New entry is younger than every currently valid one.
            if (alloc_fire) begin
                age_q[alloc_idx] <= '0;
                for (int j = 0; j < RS_DEPTH; j++) age_q[j][alloc_idx] <= valid_vec[j];
            end
        end
    end

`ifdef RS_STATS_EN
    localparam int OCC_W = $clog2(RS_DEPTH+1);
    logic [OCC_W-1:0] occ_d;

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < RS_DEPTH; i++) occ_d = occ_d + OCC_W'(ent_d[i].valid);
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_occupancy      <= '0;
            out_full_stall_cnt <= '0;
        end else begin
            out_occupancy <= occ_d;
            if (in_alloc_valid && !has_free && out_full_stall_cnt != '1)
                out_full_stall_cnt <= out_full_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rs_age_ordered.sv
// Directed self-checking bench for rs_age_ordered.
module tb_rs_age_ordered;
    logic        clk = 1'b0;
    logic        rst;
    logic        alloc_valid, alloc_ready;
    logic [4:0]  alloc_op;
    logic [3:0]  alloc_dst;
    logic        a_v, b_v;
    logic [63:0] a_val, b_val;
    logic [3:0]  a_idx, b_idx;
    logic        uses_nzcv, nzcv_v, set_nzcv;
    logic [3:0]  nzcv, nzcv_idx, cond;
    logic        bc_v, bc_set;
    logic [3:0]  bc_idx, bc_nzcv;
    logic [63:0] bc_val;
    logic        flush;
    logic [3:0]  flush_idx, head;
    logic        iss_v, iss_rdy;
    logic [4:0]  iss_op;
    logic [63:0] iss_a, iss_b;
    logic [3:0]  iss_dst, iss_nzcv, iss_cond;
    logic        iss_set;
`ifdef RS_STATS_EN
    logic [3:0]  occ;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_age_ordered dut (
        .in_clk(clk), .in_rst(rst),
        .in_alloc_valid(alloc_valid), .out_alloc_ready(alloc_ready),
        .in_alloc_op(alloc_op), .in_alloc_dst_idx(alloc_dst),
        .in_alloc_a_valid(a_v), .in_alloc_b_valid(b_v),
        .in_alloc_a_value(a_val), .in_alloc_b_value(b_val),
        .in_alloc_a_idx(a_idx), .in_alloc_b_idx(b_idx),
        .in_alloc_uses_nzcv(uses_nzcv), .in_alloc_nzcv_valid(nzcv_v),
        .in_alloc_nzcv(nzcv), .in_alloc_nzcv_idx(nzcv_idx),
        .in_alloc_set_nzcv(set_nzcv), .in_alloc_cond(cond),
        .in_bcast_valid(bc_v), .in_bcast_idx(bc_idx), .in_bcast_value(bc_val),
        .in_bcast_set_nzcv(bc_set), .in_bcast_nzcv(bc_nzcv),
        .in_flush(flush), .in_flush_idx(flush_idx), .in_rob_head_idx(head),
        .out_issue_valid(iss_v), .in_issue_ready(iss_rdy),
        .out_issue_op(iss_op), .out_issue_a(iss_a), .out_issue_b(iss_b),
        .out_issue_dst_idx(iss_dst), .out_issue_nzcv(iss_nzcv),
        .out_issue_set_nzcv(iss_set), .out_issue_cond(iss_cond)
`ifdef RS_STATS_EN
        , .out_occupancy(occ), .out_full_stall_cnt(stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid = 0; alloc_op = 0; alloc_dst = 0;
        a_v = 0; b_v = 0; a_val = 0; b_val = 0; a_idx = 0; b_idx = 0;
        uses_nzcv = 0; nzcv_v = 0; set_nzcv = 0; nzcv = 0; nzcv_idx = 0; cond = 0;
        bc_v = 0; bc_set = 0; bc_idx = 0; bc_nzcv = 0; bc_val = 0;
        flush = 0; flush_idx = 0;
    endtask

    task automatic set_alloc(input logic [3:0] dst, input logic av, input logic [63:0] aval,
                             input logic [3:0] aidx, input logic bv, input logic [63:0] bval,
                             input logic [3:0] bidx);
        alloc_valid = 1; alloc_op = 5'd1; alloc_dst = dst;
        a_v = av; a_val = aval; a_idx = aidx;
        b_v = bv; b_val = bval; b_idx = bidx;
    endtask

    task automatic test_reset();
        idle(); iss_rdy = 0; head = 0; rst = 1;
        tick(); tick();
        rst = 0;
        @(negedge clk);
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready: got %0b exp 1", alloc_ready); end
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL reset_issue_valid: got %0b exp 0", iss_v); end
        checks++; if (iss_a !== 64'd0) begin errors++; $display("FAIL reset_issue_a: got %0h exp 0", iss_a); end
    endtask

    task automatic test_basic_issue();
        tick();
        set_alloc(4'd7, 1, 64'd3, 0, 1, 64'd4, 0);
        iss_rdy = 1;
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL basic_empty_valid: got %0b exp 0", iss_v); end
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b exp 1", iss_v); end
        checks++; if (iss_a !== 64'd3) begin errors++; $display("FAIL basic_a: got %0h exp 3", iss_a); end
        checks++; if (iss_b !== 64'd4) begin errors++; $display("FAIL basic_b: got %0h exp 4", iss_b); end
        checks++; if (iss_dst !== 4'd7) begin errors++; $display("FAIL basic_dst: got %0h exp 7", iss_dst); end
        checks++; if (iss_op !== 5'd1) begin errors++; $display("FAIL basic_op: got %0h exp 1", iss_op); end
        tick();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL basic_freed: got %0b exp 0", iss_v); end
    endtask

    task automatic test_full_wakeup();
        tick(); idle(); iss_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            set_alloc(4'(k), 0, 64'd0, 4'd5, 1, 64'(100 + k), 0);
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready: got %0b exp 0", alloc_ready); end
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL full_waiting: got %0b exp 0", iss_v); end
        tick();
        bc_v = 1; bc_idx = 4'd5; bc_val = 64'h10;
        tick(); idle();
        iss_rdy = 1;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) set_alloc(4'd15, 1, 64'd1, 0, 1, 64'd1, 0);
            @(negedge clk);
            if (k == 0) begin
                checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_issue_alloc_ready: got %0b exp 0", alloc_ready); end
            end
            checks++; if (iss_v !== 1'b1) begin errors++; $display("FAIL full_issue_valid[%0d]: got %0b exp 1", k, iss_v); end
            checks++; if (iss_dst !== 4'(k)) begin errors++; $display("FAIL full_issue_dst[%0d]: got %0h exp %0h", k, iss_dst, k); end
            checks++; if (iss_a !== 64'h10) begin errors++; $display("FAIL full_issue_a[%0d]: got %0h exp 10", k, iss_a); end
            checks++; if (iss_b !== 64'(100 + k)) begin errors++; $display("FAIL full_issue_b[%0d]: got %0d exp %0d", k, iss_b, 100 + k); end
            tick(); idle();
        end
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL full_drained: got %0b exp 0", iss_v); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL full_drained_ready: got %0b exp 1", alloc_ready); end
    endtask

    task automatic test_alloc_bypass();
        tick(); idle(); iss_rdy = 0;
        set_alloc(4'd3, 0, 64'd0, 4'd2, 1, 64'd5, 0);
        bc_v = 1; bc_idx = 4'd2; bc_val = 64'd99;
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b1) begin errors++; $display("FAIL bypass_valid: got %0b exp 1", iss_v); end
        checks++; if (iss_a !== 64'd99) begin errors++; $display("FAIL bypass_a: got %0d exp 99", iss_a); end
        checks++; if (iss_b !== 64'd5) begin errors++; $display("FAIL bypass_b: got %0d exp 5", iss_b); end
        iss_rdy = 1;
        tick();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL bypass_freed: got %0b exp 0", iss_v); end
    endtask

    task automatic test_flush();
        logic [3:0] dsts [5];
        dsts = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
        tick(); idle(); iss_rdy = 0; head = 4'd14;
        for (int k = 0; k < 5; k++) begin
            set_alloc(dsts[k], 1, 64'(dsts[k]), 0, 1, 64'd0, 0);
            tick();
        end
        idle();
        flush = 1; flush_idx = 4'd0;
        set_alloc(4'd3, 1, 64'd3, 0, 1, 64'd0, 0);
        iss_rdy = 1;
        @(negedge clk);
        checks++; if (iss_dst !== 4'd14 || iss_v !== 1'b1) begin errors++; $display("FAIL flush_issue_same_cycle: got v=%0b dst=%0d exp v=1 dst=14", iss_v, iss_dst); end
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_dst !== 4'd15 || iss_v !== 1'b1) begin errors++; $display("FAIL flush_survivor15: got v=%0b dst=%0d exp v=1 dst=15", iss_v, iss_dst); end
        tick();
        @(negedge clk);
        checks++; if (iss_dst !== 4'd0 || iss_v !== 1'b1) begin errors++; $display("FAIL flush_survivor0: got v=%0b dst=%0d exp v=1 dst=0", iss_v, iss_dst); end
        tick();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL flush_squashed_gone: got v=%0b dst=%0d exp v=0", iss_v, iss_dst); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL flush_empty_ready: got %0b exp 1", alloc_ready); end
        head = 0;
    endtask

    task automatic test_nzcv();
        tick(); idle(); iss_rdy = 1;
        set_alloc(4'd6, 1, 64'd1, 0, 1, 64'd2, 0);
        uses_nzcv = 1; nzcv_v = 0; nzcv_idx = 4'd3; set_nzcv = 1; cond = 4'hA;
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL nzcv_pending: got %0b exp 0", iss_v); end
        bc_v = 1; bc_idx = 4'd3; bc_val = 64'd0; bc_set = 0; bc_nzcv = 4'b1111;
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL nzcv_no_flags_bcast: got %0b exp 0", iss_v); end
        bc_v = 1; bc_idx = 4'd3; bc_set = 1; bc_nzcv = 4'b0100;
        tick(); idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b1) begin errors++; $display("FAIL nzcv_woken: got %0b exp 1", iss_v); end
        checks++; if (iss_nzcv !== 4'b0100) begin errors++; $display("FAIL nzcv_value: got %b exp 0100", iss_nzcv); end
        checks++; if (iss_set !== 1'b1 || iss_cond !== 4'hA) begin errors++; $display("FAIL nzcv_set_cond: got set=%0b cond=%0h exp set=1 cond=a", iss_set, iss_cond); end
        tick();
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL nzcv_freed: got %0b exp 0", iss_v); end
    endtask

    task automatic test_reset_mid();
        tick(); idle(); iss_rdy = 0;
        for (int k = 1; k <= 3; k++) begin
            set_alloc(4'(k), 1, 64'(k), 0, 1, 64'(k), 0);
            tick();
        end
        idle();
        @(negedge clk);
        checks++; if (iss_v !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %0b exp 1", iss_v); end
`ifdef RS_STATS_EN
        checks++; if (occ !== 4'd3) begin errors++; $display("FAIL mid_pre_occupancy: got %0d exp 3", occ); end
`endif
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        checks++; if (iss_v !== 1'b0) begin errors++; $display("FAIL mid_issue_valid: got %0b exp 0", iss_v); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL mid_alloc_ready: got %0b exp 1", alloc_ready); end
`ifdef RS_STATS_EN
        checks++; if (occ !== 4'd0) begin errors++; $display("FAIL mid_occupancy: got %0d exp 0", occ); end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_full_wakeup();
        test_alloc_bypass();
        test_flush();
        test_nzcv();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
